// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_pkg
//  Description : Shared types and helpers for the CMP data-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmp_pkg;

    // Arbitration modes
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Tag id field is sized for up to 256 cores; narrower ids are zero-extended
    localparam int TAG_ID_W = 8;

    typedef logic [TAG_ID_W-1:0] tag_id_t;

    // Read tag travelling alongside an outstanding DMEM read
    typedef struct packed {
        logic    valid;
        tag_id_t id;
    } rd_tag_t;

    // Width of a core index: clog2(n), never less than one bit
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Single-grant request arbiter. Round-robin search starting at
//                ptr, or fixed priority (lowest index wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import cmp_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = ARB_RR,
    parameter int IDW  = id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic           found;
    int             shift;
    int             offset;
    int             winner;

    // Rotate requests so the search start sits at bit 0, then pick the first set bit
    always_comb begin
        shift     = (MODE == ARB_FIXED) ? 0 : int'(ptr);
        doubled   = {req, req};
        rotated   = N'(doubled >> shift);
        found     = 1'b0;
        offset    = 0;
        for (int i = 0; i < N; i++) begin
            if (!found && rotated[i]) begin
                found  = 1'b1;
                offset = i;
            end
        end
        winner    = (shift + offset) % N;
        grant     = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = found && (i == winner);
        end
        grant_idx = found ? IDW'(winner) : '0;
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/cmp_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_dmem_arbiter
//  Description : Arbitrates NUM_CORES core memory ports onto one synchronous
//                DMEM port, one access per cycle, and routes read data back
//                to the issuing core after the fixed DMEM read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_dmem_arbiter
    import cmp_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LAT     = 1,
    parameter int ARB_MODE   = ARB_RR
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            core_req,
    input  logic [NUM_CORES-1:0]            core_wr,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] core_wdata,
    output logic [NUM_CORES-1:0]            core_stall,
    output logic [NUM_CORES-1:0]            core_rvalid,
    output logic [DATA_WIDTH-1:0]           core_rdata,
    output logic                            mem_en,
    output logic                            mem_wr_en,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);

    localparam int ID_W = id_width(NUM_CORES);

    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       next_ptr;
    logic [NUM_CORES-1:0]  grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  grant_any;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // issue_tag is registered together with mem_*; tag_sr then delays it by RD_LAT
    rd_tag_t               issue_tag;
    rd_tag_t               tag_sr [RD_LAT];
    rd_tag_t               tag_out;

    rr_arbiter #(
        .N    (NUM_CORES),
        .MODE (ARB_MODE),
        .IDW  (ID_W)
    ) u_arb (
        .req       (core_req),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign grant_any  = |grant;
    assign core_stall = core_req & ~grant;
    assign core_rdata = mem_rdata;
    assign tag_out    = tag_sr[RD_LAT-1];
    assign next_ptr   = (int'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + 1'b1;

    // Select the granted core's write enable, address and write data
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                sel_wr    = core_wr[i];
                sel_addr  = core_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = core_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin pointer moves past the winner; fixed priority keeps it at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (ARB_MODE == ARB_RR && grant_any) begin
            ptr <= next_ptr;
        end
    end

    // DMEM request registers; address and data hold while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en    <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en    <= grant_any;
            mem_wr_en <= grant_any & sel_wr;
            if (grant_any) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
        end
    end

    // Read tags follow the access through the DMEM latency; reset drops in-flight reads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_tag <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_sr[i] <= '0;
            end
        end else begin
            issue_tag.valid <= grant_any & ~sel_wr;
            issue_tag.id    <= tag_id_t'(grant_idx);
            tag_sr[0]       <= issue_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    // Decode the returning tag into a one-hot read-valid
    always_comb begin
        core_rvalid = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_rvalid[i] = tag_out.valid && (int'(tag_out.id) == i);
        end
    end

endmodule : cmp_dmem_arbiter
`default_nettype wire

// File: doc/cmp_dmem_arbiter.md
# cmp_dmem_arbiter

Parametrised shared data-memory front end for the cardinal CMP: NUM_CORES pipeline cores, each with a private memory request port, are arbitrated onto one DMEM port. One access is issued per cycle. Read data is routed back to the issuing core after a fixed memory latency. A stall is returned to every requesting core that was not granted. The block sits between the core instances and a single synchronous DMEM in the next-generation CMP top.

## Interface
- NUM_CORES, 4: number of core ports, ≥1
- DATA_WIDTH, 64: memory data width
- ADDR_WIDTH, 32: memory address width
- RD_LAT, 1: DMEM read latency in cycles from the mem_en edge to mem_rdata valid, ≥1
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserts immediately, releases synchronously to clk
- core_req  in  NUM_CORES  per-core access request (core memEn)
- core_wr  in  NUM_CORES  per-core write enable (core memWrEn)
- core_addr  in  NUM_CORES*ADDR_WIDTH  packed addresses; core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- core_wdata  in  NUM_CORES*DATA_WIDTH  packed write data
- core_stall  out  NUM_CORES  req & ~grant, combinational
- core_rvalid  out  NUM_CORES  one-hot; read data valid for that core
- core_rdata  out  DATA_WIDTH  shared read-data bus, equal to mem_rdata
- mem_en  out  1  registered DMEM enable
- mem_wr_en  out  1  registered DMEM write enable
- mem_addr  out  ADDR_WIDTH  registered DMEM address
- mem_wdata  out  DATA_WIDTH  registered DMEM write data
- mem_rdata  in  DATA_WIDTH  DMEM read data

## Operation
- Grant is combinational from core_req and the registered priority pointer `ptr`. At most one grant per cycle.
- Round-robin mode: search starts at `ptr` and wraps modulo NUM_CORES. On a grant to core g, `ptr` ← (g+1) mod NUM_CORES. With no request, `ptr` holds.
- Fixed-priority mode: lowest-index requester wins. `ptr` is unused and stays 0.
- On the edge ending grant cycle t, the granted core's wr, addr and wdata are registered onto the mem_* outputs with mem_en=1. With no grant, mem_en=mem_wr_en=0 and mem_addr/mem_wdata hold their previous values.
- A granted read pushes {valid=1, id=g} into an RD_LAT-deep tag shift register. Writes and idle cycles push valid=0.
- core_rvalid = onehot(tag_out.id) when tag_out.valid, otherwise 0. core_rdata passes mem_rdata through.
- Core protocol: a stalled core holds req, wr, addr and wdata unchanged until it is granted.
- Reset values: ptr=0, mem_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, all tag valids=0, core_rvalid=0.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced after reset is released.
- NUM_CORES=1: grant = core_req[0], core_stall is always 0.

## Timing
- Grant and stall: same cycle as req (0 latency).
- mem_* outputs: 1 cycle after the grant cycle.
- Read return: core_rvalid is asserted exactly 1+RD_LAT cycles after the grant cycle, for one cycle.
- Throughput: one access per cycle with no bubbles. Reads and writes may interleave back-to-back. A write issued after a read does not disturb that read's return.
- Worst-case wait in round-robin mode, with continuously requesting cores: NUM_CORES-1 cycles.

## Structure
- Shared package cmp_pkg holds:
  - constants ARB_RR=0 and ARB_FIXED=1
  - a function returning the core-id width, clog2(NUM_CORES) with a minimum of 1
  - the read-tag struct {valid, id}
- Sub-module rr_arbiter (parameters N and MODE): inputs req and ptr; outputs one-hot grant and its encoded index. The top holds ptr, the mem_* registers and the tag pipeline.

## Test plan
- All 4 cores issue reads simultaneously at cycle 0 (addr 0x10, 0x20, 0x30, 0x40), RD_LAT=1, round-robin:
  - grants go to cores 0,1,2,3 in cycles 0–3
  - each core's stall drops in its grant cycle
  - core_rvalid is 0001, 0010, 0100, 1000 in cycles 2–5, with matching rdata
- Core 2 writes 0xDEAD_BEEF to 0x100 in cycle 0 and reads 0x100 in cycle 1:
  - mem_wr_en=1 in cycle 1
  - core_rvalid[2] in cycle 3 with rdata 0xDEAD_BEEF
  - no rvalid is produced for the write
- ARB_MODE=1, cores 0 and 3 request continuously: core 0 is granted every cycle and core_stall[3] stays 1. Dropping core 0's req grants core 3 in the same cycle.
- Round-robin fairness: cores 1 and 3 request continuously for 8 cycles. Grants alternate 1,3,1,3…, and ptr wraps 3→0 correctly.
- Reset asserted with 2 reads in flight (RD_LAT=3): core_rvalid and mem_en go 0 immediately and ptr=0. After reset is released, no stale rvalid appears.
- NUM_CORES=1, RD_LAT=2, back-to-back reads for 5 cycles: stall is always 0 and 5 consecutive rvalids arrive starting 3 cycles after the first request.
